ctrl_pipe: RTL and testbench

Registered, parametrised successor to the single-cycle opcode decoder. It decodes the 5-bit opcode with a combinational sub-module and latches the control bundle into the ID/EX pipeline register, with stall and flush (bubble) handling. It also runs a sequential halt-drain and SIIC/RTI exception state machine. It sits between fetch/decode and execute; downstream stages consume only registered ex_* outputs.

---
 rtl/ctrl_pkg.sv | 85 ++++++++
 rtl/ctrl_pipe_if.sv | 29 ++
 rtl/ctrl_decode.sv | 108 ++++++++++
 rtl/ctrl_pipe.sv | 104 ++++++++++
 tb/tb_ctrl_pipe.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_pkg.sv
// Shared definitions for the ID/EX control pipeline: opcodes, field encodings,
// control-bundle layout and FSM state encoding.
package ctrl_pkg;

    localparam int OP_W   = 5;
    localparam int CTRL_W = 26;

    localparam logic [4:0] OP_HALT = 5'b00000;
    localparam logic [4:0] OP_NOP  = 5'b00001;
    localparam logic [4:0] OP_SIIC = 5'b00010;
    localparam logic [4:0] OP_RTI  = 5'b00011;
    localparam logic [4:0] OP_J    = 5'b00100;
    localparam logic [4:0] OP_JR   = 5'b00101;
    localparam logic [4:0] OP_JAL  = 5'b00110;
    localparam logic [4:0] OP_JALR = 5'b00111;
    localparam logic [4:0] OP_ST   = 5'b10000;
    localparam logic [4:0] OP_LD   = 5'b10001;
    localparam logic [4:0] OP_SLBI = 5'b10010;
    localparam logic [4:0] OP_STU  = 5'b10011;
    localparam logic [4:0] OP_LBI  = 5'b11000;

    localparam logic [4:0] ALUC_RTI = 5'b00001;

    localparam logic [1:0] DRS_NONE = 2'b00;
    localparam logic [1:0] DRS_RFMT = 2'b01;
    localparam logic [1:0] DRS_LINK = 2'b10;
    localparam logic [1:0] DRS_IFMT = 2'b11;

    localparam logic [2:0] IMM_NONE = 3'b000;
    localparam logic [2:0] IMM_ZX8  = 3'b001;
    localparam logic [2:0] IMM_I5   = 3'b100;
    localparam logic [2:0] IMM_I8   = 3'b101;
    localparam logic [2:0] IMM_D11  = 3'b110;

    // The listed bundle is 25 bits wide; the top bit of the 26-bit bus is reserved and always 0.
    localparam int B_RSVD      = 25;
    localparam int B_REGWRITE  = 24;
    localparam int B_MEMENABLE = 23;
    localparam int B_MEMWR     = 22;
    localparam int B_VAL2REG   = 21;
    localparam int B_ALUSEL    = 20;
    localparam int B_LINK      = 19;
    localparam int B_LBI       = 18;
    localparam int B_PCSEL     = 17;
    localparam int B_REGJMP    = 16;
    localparam int B_BFLAG     = 15;
    localparam int B_JFLAG     = 14;
    localparam int B_SIIC      = 13;
    localparam int B_HALT      = 12;
    localparam int B_DRS_LO    = 10;
    localparam int B_IMM_LO    = 7;
    localparam int B_ALUC_LO   = 2;
    localparam int B_CTRLERR   = 1;
    localparam int B_RTI       = 0;

    typedef struct packed {
        logic       rsvd;
        logic       reg_write;
        logic       mem_enable;
        logic       mem_wr;
        logic       val2reg;
        logic       alu_sel;
        logic       link;
        logic       lbi;
        logic       pc_sel;
        logic       reg_jmp;
        logic       b_flag;
        logic       j_flag;
        logic       siic;
        logic       halt;
        logic [1:0] dest_sel;
        logic [2:0] imm_sel;
        logic [4:0] alu_cntrl;
        logic       ctrl_err;
        logic       rti;
    } ctrl_t;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_EXC    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

endpackage

// File: rtl/ctrl_pipe_if.sv
// Fetch/decode-side bus of the control pipeline; master drives instructions,
// slave (ctrl_pipe) returns the registered ID/EX bundle and control status.
interface ctrl_pipe_if import ctrl_pkg::*; #(
    parameter int OPW = OP_W,
    parameter int PCW = 16
);
    logic              instr_valid;
    logic [OPW-1:0]    instr_op;
    logic [PCW-1:0]    pc_inc;
    logic              stall;
    logic              flush;
    logic              ex_valid;
    logic [CTRL_W-1:0] ex_ctrl;
    logic              fetch_stop;
    logic              halted;
    logic              redirect;
    logic [PCW-1:0]    redirect_pc;
    logic [PCW-1:0]    epc;

    modport master (
        output instr_valid, instr_op, pc_inc, stall, flush,
        input  ex_valid, ex_ctrl, fetch_stop, halted, redirect, redirect_pc, epc
    );

    modport slave (
        input  instr_valid, instr_op, pc_inc, stall, flush,
        output ex_valid, ex_ctrl, fetch_stop, halted, redirect, redirect_pc, epc
    );
endinterface

// File: rtl/ctrl_decode.sv
// Purely combinational opcode to control-bundle decoder; the table is defined
// for 5-bit opcodes only.
module ctrl_decode import ctrl_pkg::*; #(
    parameter int OPW = OP_W
) (
    input  logic [OPW-1:0]    op_i,
    output logic [CTRL_W-1:0] ctrl_o
);

    ctrl_t c;

    always_comb begin
        c           = '0;
        c.alu_cntrl = op_i;
        casez (op_i)
            5'b000??: begin
                c.alu_sel  = 1'b1;
                c.dest_sel = DRS_IFMT;
                c.imm_sel  = IMM_I5;
                c.halt     = (op_i == OP_HALT);
                c.siic     = (op_i == OP_SIIC);
                if (op_i == OP_RTI) begin
                    c.rti       = 1'b1;
                    c.alu_cntrl = ALUC_RTI;
                end
            end
            5'b010?0, 5'b101?0: begin
                c.reg_write = 1'b1;
                c.alu_sel   = 1'b1;
                c.dest_sel  = DRS_IFMT;
                c.imm_sel   = IMM_I5;
            end
            // Illegal encodings collapse to a NOP carrying only the error flag.
            5'b010?1, 5'b101?1: begin
                c          = '0;
                c.ctrl_err = 1'b1;
            end
            OP_ST: begin
                c.mem_enable = 1'b1;
                c.mem_wr     = 1'b1;
                c.alu_sel    = 1'b1;
                c.dest_sel   = DRS_IFMT;
                c.imm_sel    = IMM_I5;
            end
            OP_LD: begin
                c.mem_enable = 1'b1;
                c.val2reg    = 1'b1;
                c.reg_write  = 1'b1;
                c.alu_sel    = 1'b1;
                c.dest_sel   = DRS_IFMT;
                c.imm_sel    = IMM_I5;
            end
            OP_STU: begin
                c.alu_sel    = 1'b1;
                c.imm_sel    = IMM_I5;
                c.reg_write  = 1'b1;
                c.mem_enable = 1'b1;
                c.mem_wr     = 1'b1;
            end
            5'b11001, 5'b1101?, 5'b111??: begin
                c.dest_sel  = DRS_RFMT;
                c.reg_write = 1'b1;
            end
            5'b011??: begin
                c.imm_sel = IMM_I8;
            end
            OP_LBI: begin
                c.alu_sel   = 1'b1;
                c.reg_write = 1'b1;
                c.lbi       = 1'b1;
                c.imm_sel   = IMM_I8;
            end
            OP_SLBI: begin
                c.alu_sel   = 1'b1;
                c.reg_write = 1'b1;
                c.imm_sel   = IMM_ZX8;
            end
            OP_J, OP_JAL: begin
                c.j_flag    = 1'b1;
                c.b_flag    = 1'b1;
                c.imm_sel   = IMM_D11;
                c.alu_sel   = 1'b1;
                c.dest_sel  = DRS_LINK;
                c.link      = (op_i == OP_JAL);
                c.reg_write = (op_i == OP_JAL);
            end
            OP_JR: begin
                c.reg_jmp  = 1'b1;
                c.b_flag   = 1'b1;
                c.imm_sel  = IMM_I8;
                c.alu_sel  = 1'b1;
                c.dest_sel = DRS_LINK;
            end
            OP_JALR: begin
                c.reg_jmp   = 1'b1;
                c.link      = 1'b1;
                c.reg_write = 1'b1;
                c.imm_sel   = IMM_I8;
                c.alu_sel   = 1'b1;
                c.dest_sel  = DRS_LINK;
            end
            default: c = '0;
        endcase
    end

    assign ctrl_o = c;

endmodule

// File: rtl/ctrl_pipe.sv
// ID/EX control pipeline register with stall/flush handling, plus the
// SIIC/RTI exception and halt-drain state machine.
module ctrl_pipe import ctrl_pkg::*; #(
    parameter int             OPW     = OP_W,
    parameter int             PCW     = 16,
    parameter int             DRAIN   = 3,
    parameter logic [PCW-1:0] EXC_VEC = 16'h0002
) (
    input  logic       clk,
    input  logic       rst,
    ctrl_pipe_if.slave bus
);

    logic [CTRL_W-1:0] dec;
    logic              accept;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              ex_valid_q;
    logic [CTRL_W-1:0] ex_ctrl_q;
    logic [PCW-1:0]    epc_q;
    logic [PCW-1:0]    redirect_pc_q;
    logic              rti_redir_q;

    ctrl_decode #(.OPW(OPW)) u_decode (
        .op_i   (bus.instr_op),
        .ctrl_o (dec)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // SIIC wins over Halt only notionally: a single opcode never carries both.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_RUN: begin
                if (accept && dec[B_SIIC]) begin
                    state_d = ST_EXC;
                end else if (accept && dec[B_HALT]) begin
                    state_d = ST_DRAIN;
                    cnt_d   = 4'(DRAIN - 1);
                end
            end
            ST_EXC:    state_d = ST_RUN;
            ST_DRAIN: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_HALTED;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_RUN;
        endcase
    end

    always_comb begin
        accept         = bus.instr_valid && !bus.stall && !bus.flush && (state_q == ST_RUN);
        bus.fetch_stop = (state_q == ST_DRAIN) || (state_q == ST_HALTED);
        bus.halted     = (state_q == ST_HALTED);
        bus.redirect   = (state_q == ST_EXC) || rti_redir_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_q    <= 1'b0;
            ex_ctrl_q     <= '0;
            epc_q         <= '0;
            redirect_pc_q <= '0;
            rti_redir_q   <= 1'b0;
        end else begin
            if (bus.flush) begin
                ex_valid_q <= 1'b0;
                ex_ctrl_q  <= '0;
            end else if (!bus.stall) begin
                ex_valid_q <= accept;
                ex_ctrl_q  <= accept ? dec : '0;
            end
            rti_redir_q <= accept && dec[B_RTI];
            if (accept && dec[B_RTI]) begin
                redirect_pc_q <= epc_q;
            end
            if (accept && dec[B_SIIC]) begin
                epc_q         <= bus.pc_inc;
                redirect_pc_q <= EXC_VEC;
            end
        end
    end

    assign bus.ex_valid    = ex_valid_q;
    assign bus.ex_ctrl     = ex_ctrl_q;
    assign bus.epc         = epc_q;
    assign bus.redirect_pc = redirect_pc_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe: a cycle-level behavioural model checked every
// cycle, plus hand-computed literal expectations at key points.
module tb_ctrl_pipe;

    localparam int          DRAIN_P = 3;
    localparam logic [15:0] VEC_P   = 16'h0002;

    // Literal bundles, grouped as rsvd | RW ME MW V2R ALU | LNK LBI PCS RJ B J SIIC HALT | DRS | IMM | ALUC | ERR RTI
    localparam logic [25:0] L_LD   = 26'b0_11011_00000000_11_100_10001_00;
    localparam logic [25:0] L_ADD  = 26'b0_10000_00000000_01_000_11011_00;
    localparam logic [25:0] L_SUB  = 26'b0_10000_00000000_01_000_11010_00;
    localparam logic [25:0] L_JAL  = 26'b0_10001_10001100_10_110_00110_00;
    localparam logic [25:0] L_SIIC = 26'b0_00001_00000010_11_100_00010_00;
    localparam logic [25:0] L_RTI  = 26'b0_00001_00000000_11_100_00001_01;
    localparam logic [25:0] L_HALT = 26'b0_00001_00000001_11_100_00000_00;
    localparam logic [25:0] L_ILL  = 26'b0_00000_00000000_00_000_00000_10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ctrl_pipe_if #(.OPW(5), .PCW(16)) bus ();

    ctrl_pipe #(.OPW(5), .PCW(16), .DRAIN(DRAIN_P), .EXC_VEC(VEC_P)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [25:0] spec_decode(input logic [4:0] op);
        logic rw, me, mw, v2r, alu, lnk, lbi, rj, b, j, siic, halt, err, rti;
        logic [1:0] drs;
        logic [2:0] imm;
        logic [4:0] aluc;
        {rw, me, mw, v2r, alu, lnk, lbi, rj, b, j, siic, halt, err, rti} = '0;
        drs  = 2'b00;
        imm  = 3'b000;
        aluc = op;
        if (op[4:2] == 3'b000) begin
            alu = 1; drs = 2'b11; imm = 3'b100;
            halt = (op == 5'd0);
            siic = (op == 5'd2);
            if (op == 5'd3) begin rti = 1; aluc = 5'd1; end
        end else if (op[4:2] == 3'b010 || op[4:2] == 3'b101) begin
            if (op[0]) begin err = 1; aluc = 5'd0; end
            else begin rw = 1; alu = 1; drs = 2'b11; imm = 3'b100; end
        end else if (op == 5'd16 || op == 5'd17) begin
            me = 1; alu = 1; drs = 2'b11; imm = 3'b100;
            if (op == 5'd16) mw = 1;
            else begin v2r = 1; rw = 1; end
        end else if (op == 5'd19) begin
            alu = 1; imm = 3'b100; rw = 1; me = 1; mw = 1;
        end else if (op == 5'd25 || op[4:1] == 4'b1101 || op[4:2] == 3'b111) begin
            drs = 2'b01; rw = 1;
        end else if (op[4:2] == 3'b011) begin
            imm = 3'b101;
        end else if (op == 5'd24) begin
            alu = 1; rw = 1; lbi = 1; imm = 3'b101;
        end else if (op == 5'd18) begin
            alu = 1; rw = 1; imm = 3'b001;
        end else if (op == 5'd4 || op == 5'd6) begin
            j = 1; b = 1; imm = 3'b110; alu = 1; drs = 2'b10;
            if (op == 5'd6) begin lnk = 1; rw = 1; end
        end else if (op == 5'd5) begin
            rj = 1; b = 1; imm = 3'b101; alu = 1; drs = 2'b10;
        end else begin
            rj = 1; lnk = 1; rw = 1; imm = 3'b101; alu = 1; drs = 2'b10;
        end
        return {1'b0, rw, me, mw, v2r, alu, lnk, lbi, 1'b0, rj, b, j, siic, halt, drs, imm, aluc, err, rti};
    endfunction

    // Model: what the outputs must show after each edge.
    logic        m_valid;
    logic [25:0] m_ctrl;
    logic [15:0] m_epc, m_rpc;
    logic        m_redir, m_exc;
    int          m_edge, m_halt_edge;
    logic [25:0] md;
    logic        m_acc;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid = 0; m_ctrl = '0; m_epc = '0; m_rpc = '0;
            m_redir = 0; m_exc = 0; m_edge = 0; m_halt_edge = -1;
        end else begin
            m_edge++;
            md    = spec_decode(bus.instr_op);
            m_acc = bus.instr_valid && !bus.stall && !bus.flush && (m_halt_edge < 0) && !m_exc;
            if (bus.flush) begin
                m_valid = 0; m_ctrl = '0;
            end else if (!bus.stall) begin
                m_valid = m_acc;
                m_ctrl  = m_acc ? md : '0;
            end
            m_exc   = m_acc && md[13];
            m_redir = m_acc && (md[13] || md[0]);
            if (m_acc && md[0]) m_rpc = m_epc;
            if (m_acc && md[13]) begin m_rpc = VEC_P; m_epc = bus.pc_inc; end
            if (m_acc && md[12]) m_halt_edge = m_edge;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("ex_valid",    32'(bus.ex_valid),    32'(m_valid));
            chk("ex_ctrl",     32'(bus.ex_ctrl),     32'(m_ctrl));
            chk("redirect",    32'(bus.redirect),    32'(m_redir));
            chk("redirect_pc", 32'(bus.redirect_pc), 32'(m_rpc));
            chk("epc",         32'(bus.epc),         32'(m_epc));
            chk("fetch_stop",  32'(bus.fetch_stop),  32'(m_halt_edge >= 0));
            chk("halted",      32'(bus.halted),      32'(m_halt_edge >= 0 && m_edge >= m_halt_edge + DRAIN_P));
        end
    end

    task automatic cyc(input logic v, input logic [4:0] op, input logic [15:0] pc,
                       input logic st, input logic fl);
        bus.instr_valid = v;
        bus.instr_op    = op;
        bus.pc_inc      = pc;
        bus.stall       = st;
        bus.flush       = fl;
        @(negedge clk);
        $display("txn op=%b v=%b st=%b fl=%b pc=%h | ex_valid=%b ex_ctrl=%h redir=%b rpc=%h epc=%h fstop=%b halted=%b",
                 op, v, st, fl, pc, bus.ex_valid, bus.ex_ctrl, bus.redirect,
                 bus.redirect_pc, bus.epc, bus.fetch_stop, bus.halted);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ex_valid"},   32'(bus.ex_valid),    32'd0);
        chk({tag, "_ex_ctrl"},    32'(bus.ex_ctrl),     32'd0);
        chk({tag, "_fetch_stop"}, 32'(bus.fetch_stop),  32'd0);
        chk({tag, "_halted"},     32'(bus.halted),      32'd0);
        chk({tag, "_redirect"},   32'(bus.redirect),    32'd0);
        chk({tag, "_rpc"},        32'(bus.redirect_pc), 32'd0);
        chk({tag, "_epc"},        32'(bus.epc),         32'd0);
    endtask

    task automatic pulse_reset();
        #2 rst = 1'b1;
        #1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bus.instr_valid = 0; bus.instr_op = '0; bus.pc_inc = '0; bus.stall = 0; bus.flush = 0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;

        cyc(1, 5'b10001, 16'h0010, 0, 0);
        chk("ld_ctrl", 32'(bus.ex_ctrl), 32'(L_LD));
        chk("ld_valid", 32'(bus.ex_valid), 32'd1);

        cyc(1, 5'b11011, 16'h0012, 0, 0);
        chk("add_ctrl", 32'(bus.ex_ctrl), 32'(L_ADD));
        cyc(1, 5'b11010, 16'h0014, 1, 0);
        chk("stall1_hold", 32'(bus.ex_ctrl), 32'(L_ADD));
        cyc(1, 5'b11010, 16'h0014, 1, 0);
        chk("stall2_hold", 32'(bus.ex_ctrl), 32'(L_ADD));
        cyc(1, 5'b11010, 16'h0014, 0, 0);
        chk("sub_ctrl", 32'(bus.ex_ctrl), 32'(L_SUB));

        cyc(1, 5'b00110, 16'h0016, 0, 1);
        chk("jal_flush_valid", 32'(bus.ex_valid), 32'd0);
        chk("jal_flush_ctrl",  32'(bus.ex_ctrl),  32'd0);
        cyc(1, 5'b00110, 16'h0016, 0, 0);
        chk("jal_ctrl", 32'(bus.ex_ctrl), 32'(L_JAL));

        cyc(1, 5'b00010, 16'h0040, 0, 0);
        chk("siic_ctrl", 32'(bus.ex_ctrl),     32'(L_SIIC));
        chk("siic_epc",  32'(bus.epc),         32'h0040);
        chk("siic_redir", 32'(bus.redirect),   32'd1);
        chk("siic_rpc",  32'(bus.redirect_pc), 32'h0002);
        cyc(1, 5'b11011, 16'h0042, 0, 0);
        chk("exc_redir_off", 32'(bus.redirect), 32'd0);
        chk("exc_no_accept", 32'(bus.ex_valid), 32'd0);
        cyc(1, 5'b00011, 16'h0090, 0, 0);
        chk("rti_ctrl",  32'(bus.ex_ctrl),     32'(L_RTI));
        chk("rti_redir", 32'(bus.redirect),    32'd1);
        chk("rti_rpc",   32'(bus.redirect_pc), 32'h0040);
        cyc(0, 5'b00000, 16'h0000, 0, 0);
        chk("rti_redir_off", 32'(bus.redirect), 32'd0);

        cyc(1, 5'b00000, 16'h0050, 1, 0);
        chk("halt_stall_nofs", 32'(bus.fetch_stop), 32'd0);
        cyc(1, 5'b00000, 16'h0050, 0, 1);
        chk("halt_flush_nofs", 32'(bus.fetch_stop), 32'd0);
        cyc(1, 5'b00010, 16'h0060, 0, 1);
        chk("siic_flush_noredir", 32'(bus.redirect), 32'd0);
        chk("siic_flush_epc",     32'(bus.epc),      32'h0040);

        cyc(1, 5'b01011, 16'h0070, 0, 0);
        chk("illegal_ctrl", 32'(bus.ex_ctrl), 32'(L_ILL));

        for (int op = 1; op < 32; op++) begin
            cyc(1, 5'(op), 16'(op * 4), (op % 7) == 3, (op % 11) == 5);
            if (op == 2) cyc(0, 5'd0, 16'd0, 0, 0);
        end

        cyc(1, 5'b00000, 16'h0100, 0, 0);
        chk("halt_ctrl",   32'(bus.ex_ctrl),    32'(L_HALT));
        chk("halt_fstop",  32'(bus.fetch_stop), 32'd1);
        chk("halt_early0", 32'(bus.halted),     32'd0);
        cyc(1, 5'b11011, 16'h0102, 0, 0);
        chk("halt_early1", 32'(bus.halted), 32'd0);
        cyc(1, 5'b11011, 16'h0104, 0, 0);
        chk("halt_early2", 32'(bus.halted), 32'd0);
        cyc(1, 5'b11011, 16'h0106, 0, 0);
        chk("halted_set", 32'(bus.halted), 32'd1);
        cyc(1, 5'b00010, 16'h0108, 0, 0);
        cyc(1, 5'b10001, 16'h010a, 0, 0);
        chk("halted_sticky", 32'(bus.halted),   32'd1);
        chk("halted_bubble", 32'(bus.ex_valid), 32'd0);

        pulse_reset();
        cyc(1, 5'b00000, 16'h0200, 0, 0);
        cyc(0, 5'b00000, 16'h0000, 0, 0);
        #2 rst = 1'b1;
        #1;
        chk_all_zero("drain_rst");
        @(negedge clk);
        rst = 1'b0;
        cyc(1, 5'b10001, 16'h0210, 0, 0);
        chk("post_rst_accept", 32'(bus.ex_valid), 32'd1);
        repeat (4) cyc(0, 5'b00000, 16'h0000, 0, 0);
        chk("post_rst_not_halted", 32'(bus.halted), 32'd0);

        cyc(1, 5'b00010, 16'h0300, 0, 0);
        #2 rst = 1'b1;
        #1;
        chk_all_zero("exc_rst");
        @(negedge clk);
        rst = 1'b0;
        cyc(1, 5'b11011, 16'h0302, 0, 0);
        chk("post_exc_rst_accept", 32'(bus.ex_valid), 32'd1);
        cyc(0, 5'b00000, 16'h0000, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
